// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch FIFO stores each instruction together with the PC it was fetched from.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Redirect targets may carry junk in the byte-offset bits; fetch is word granular.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Small synchronous FIFO with a combinational head view and a single-cycle flush.
// Pointers wrap modulo DEPTH (power of two); count distinguishes full from empty.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     flush,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = $bits(entry_t);

    logic [AW-1:0]             wr_ptr_reg;
    logic [AW-1:0]             rd_ptr_reg;
    logic [CW-1:0]             count_reg;
    logic [DEPTH-1:0][EW-1:0]  slots_flat;

    // One register per slot, written only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            entry_t slot_reg;

            always_ff @(posedge CLK) begin
                if (push && (wr_ptr_reg == AW'(gi))) begin
                    slot_reg <= push_data;
                end
            end

            assign slots_flat[gi] = slot_reg;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = entry_t'(slots_flat[rd_ptr_reg]);
    assign count = count_reg;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the fetch PC, issues credit-limited reads to a one-cycle
// instruction memory and queues {pc, instr} pairs for the decode stage.
module ifetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                CLK,
    input  logic                RST,
    output logic                imem_en,
    output logic [29:0]         imem_addr,
    input  logic [INSTR_W-1:0]  imem_rd,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [31:0]         out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fpc_reg;
    logic [31:0]   inflight_pc_reg;
    logic          inflight_reg;

    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          pop;
    logic          push;
    logic          issue;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign out_valid = (count != '0) && !redirect && !RST;
    assign pop       = out_valid && out_ready;

    // Entries already buffered plus the one response still on its way, net of
    // this cycle's pop, must leave room for the request we are about to issue.
    assign occupancy = {1'b0, count}
                     + {{CW{1'b0}}, inflight_reg}
                     - {{CW{1'b0}}, pop};
    assign issue     = !RST && !redirect && (occupancy < (CW + 1)'(DEPTH));

    assign imem_en   = issue;
    assign imem_addr = fpc_reg[31:2];

    // A response that returns during a redirect belongs to the wrong path.
    assign push             = inflight_reg && !redirect;
    assign push_entry.pc    = inflight_pc_reg;
    assign push_entry.instr = imem_rd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fpc_reg         <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= RESET_PC;
        end else if (redirect) begin
            fpc_reg      <= align_pc(redirect_pc);
            inflight_reg <= 1'b0;
        end else if (issue) begin
            fpc_reg         <= fpc_reg + 32'(PC_STEP);
            inflight_reg    <= 1'b1;
            inflight_pc_reg <= fpc_reg;
        end else begin
            inflight_reg <= 1'b0;
        end
    end

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count)
    );

    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based fetch model.
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [29:0] imem_addr;
    logic [31:0] imem_rd = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int errors = 0;
    int checks = 0;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK         (clk),
        .RST         (rst),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [29:0] a);
        return 32'h1000_0000 + {2'b00, a};
    endfunction

    // Instruction memory: synchronous read, data one cycle after the request.
    always @(posedge clk) begin
        if (imem_en) imem_rd <= rom(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of {pc, instr} and the fetch bookkeeping.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc = RESET_PC;
    bit          m_inflight = 0;
    logic [31:0] m_inflight_pc = '0;

    always @(negedge clk) begin
        bit   exp_valid, exp_en, do_pop;
        ent_t e;
        exp_valid = (mq.size() != 0) && !redirect && !rst;
        do_pop    = exp_valid && out_ready;
        exp_en    = !rst && !redirect &&
                    ((mq.size() + int'(m_inflight) - int'(do_pop)) < DEPTH);

        chk("m_en", {31'b0, imem_en}, {31'b0, exp_en});
        if (exp_en) chk("m_addr", {2'b00, imem_addr}, {2'b00, m_fpc[31:2]});
        chk("m_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            chk("m_pc", out_pc, mq[0].pc);
            chk("m_instr", out_instr, mq[0].instr);
        end

        if (rst) begin
            mq.delete();
            m_inflight = 0;
            m_fpc = RESET_PC;
        end else if (redirect) begin
            mq.delete();
            m_inflight = 0;
            m_fpc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (m_inflight) begin
                e.pc    = m_inflight_pc;
                e.instr = rom(m_inflight_pc[31:2]);
                mq.push_back(e);
            end
            if (exp_en) begin
                m_inflight_pc = m_fpc;
                m_fpc = m_fpc + 32'd4;
                m_inflight = 1;
            end else begin
                m_inflight = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Leaves the bench in cycle 0 (first cycle with RST low).
    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int issues;
        int got;

        // Streaming
        do_reset();
        out_ready = 1'b1;
        mid();
        chk("t1_en0", {31'b0, imem_en}, 32'd1);
        chk("t1_addr0", {2'b00, imem_addr}, 32'h0);
        chk("t1_valid0", {31'b0, out_valid}, 32'd0);
        tick();
        tick();
        mid();
        chk("t1_valid2", {31'b0, out_valid}, 32'd1);
        chk("t1_pc2", out_pc, 32'h0);
        chk("t1_instr2", out_instr, 32'h1000_0000);
        tick();
        mid();
        chk("t1_pc3", out_pc, 32'h4);
        chk("t1_instr3", out_instr, 32'h1000_0001);
        repeat (8) tick();

        // Backpressure
        do_reset();
        issues = 0;
        for (int i = 0; i < 10; i++) begin
            mid();
            if (imem_en) issues++;
            tick();
        end
        chk("t2_issues", 32'(issues), 32'd4);
        mid();
        chk("t2_en_stalled", {31'b0, imem_en}, 32'd0);
        tick();
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got < 5; i++) begin
            mid();
            if (out_valid) begin
                chk("t2_order", out_pc, 32'(got * 4));
                got++;
            end
            tick();
        end
        chk("t2_delivered", 32'(got), 32'd5);

        // Redirect with data in flight
        do_reset();
        out_ready = 1'b1;
        repeat (3) tick();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        mid();
        chk("t3_valid_R", {31'b0, out_valid}, 32'd0);
        chk("t3_en_R", {31'b0, imem_en}, 32'd0);
        tick();
        redirect = 1'b0;
        mid();
        chk("t3_addr_R1", {2'b00, imem_addr}, 32'h10);
        chk("t3_valid_R1", {31'b0, out_valid}, 32'd0);
        tick();
        mid();
        chk("t3_valid_R2", {31'b0, out_valid}, 32'd0);
        tick();
        mid();
        chk("t3_valid_R3", {31'b0, out_valid}, 32'd1);
        chk("t3_pc_R3", out_pc, 32'h40);
        chk("t3_instr_R3", out_instr, 32'h1000_0010);
        for (int i = 0; i < 6; i++) begin
            tick();
            mid();
            if (out_valid) chk("t3_no_stale", {31'b0, out_pc >= 32'h40}, 32'd1);
        end

        // Unaligned redirect
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h43;
        tick();
        redirect = 1'b0;
        mid();
        chk("t4_addr", {2'b00, imem_addr}, 32'h10);
        tick();
        tick();
        mid();
        chk("t4_pc", out_pc, 32'h40);

        // Redirect during handshake
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        mid();
        chk("t5_nonempty", {31'b0, out_valid}, 32'd1);
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        out_ready = 1'b1;
        mid();
        chk("t5_valid_R", {31'b0, out_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        mid();
        chk("t5_empty", {31'b0, out_valid}, 32'd0);
        chk("t5_addr", {2'b00, imem_addr}, 32'h40);
        tick();
        mid();
        chk("t5_empty2", {31'b0, out_valid}, 32'd0);
        tick();
        mid();
        chk("t5_pc", out_pc, 32'h100);

        // Reset mid-stream with 3 entries buffered
        do_reset();
        repeat (4) tick();
        rst = 1'b1;
        mid();
        chk("t6_valid_rst", {31'b0, out_valid}, 32'd0);
        chk("t6_en_rst", {31'b0, imem_en}, 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        mid();
        chk("t6_addr0", {2'b00, imem_addr}, 32'h0);
        chk("t6_valid0", {31'b0, out_valid}, 32'd0);
        tick();
        mid();
        chk("t6_valid1", {31'b0, out_valid}, 32'd0);
        tick();
        mid();
        chk("t6_pc2", out_pc, 32'h0);
        chk("t6_instr2", out_instr, 32'h1000_0000);

        // Randomized traffic, including redirects near the top of the address space
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            redirect = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0, 1:    redirect_pc = 32'($urandom_range(0, 255));
                2:       redirect_pc = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
                default: redirect_pc = $urandom;
            endcase
            out_ready = ($urandom_range(0, 9) < 7);
        end

        tick();
        rst = 1'b0;
        redirect = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
